// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle controller: FSM states,
// opcode and ALU-op constants, and the registered decoded-field bundle.
package ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      EXEC,
      MEM,
      WB,
      HALT
   } state_e;

   localparam logic [1:0] OP_R    = 2'b00;
   localparam logic [1:0] OP_ADDI = 2'b01;
   localparam logic [1:0] OP_LW   = 2'b10;
   localparam logic [1:0] OP_SW   = 2'b11;

   // Must track the encoding the existing ALU already decodes.
   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] SLL = 2'b10;
   localparam logic [1:0] AND = 2'b11;

   typedef struct packed {
      logic [1:0] opcode;
      logic [1:0] rs1;
      logic [1:0] rs2;
      logic [1:0] rd;
      logic [7:0] imm;
      logic [1:0] alu_op;
      logic       alu_src;
   } dec_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Fetch, data-memory, register-file and ALU control signals of the multicycle
// controller; master is the controller side, slave the memory/datapath side.
interface multicycle_ctrl_if;
   logic       imem_req;
   logic       imem_ready;
   logic [7:0] imem_rdata;
   logic [7:0] pc;
   logic [1:0] rs1_addr;
   logic [1:0] rs2_addr;
   logic [1:0] rd_addr;
   logic [7:0] imm;
   logic [1:0] alu_op;
   logic       alu_src;
   logic       mem_req;
   logic       mem_we;
   logic       mem_ready;
   logic       reg_we;
   logic       wb_sel;
   logic       retired;
   logic       err;

   modport master (
      output imem_req, pc, rs1_addr, rs2_addr, rd_addr, imm, alu_op, alu_src,
             mem_req, mem_we, reg_we, wb_sel, retired, err,
      input  imem_ready, imem_rdata, mem_ready
   );

   modport slave (
      input  imem_req, pc, rs1_addr, rs2_addr, rd_addr, imm, alu_op, alu_src,
             mem_req, mem_we, reg_we, wb_sel, retired, err,
      output imem_ready, imem_rdata, mem_ready
   );
endinterface

// File: rtl/instr_decode.sv
// Combinational field extraction and immediate extension for the 8-bit ISA.
// Fields an opcode does not use are driven to 0.
module instr_decode
   import ctrl_pkg::*;
(
   input  logic [7:0] instr,
   output dec_t       dec
);
   always_comb begin
      dec        = '0;
      dec.opcode = instr[7:6];
      case (instr[7:6])
         OP_R: begin
            dec.rd     = instr[5:4];
            dec.rs1    = instr[5:4];
            dec.rs2    = instr[3:2];
            dec.alu_op = instr[1:0];
         end
         OP_ADDI: begin
            dec.rd      = instr[5:4];
            dec.rs1     = instr[5:4];
            dec.imm     = {{4{instr[3]}}, instr[3:0]};
            dec.alu_src = 1'b1;
            dec.alu_op  = ADD;
         end
         OP_LW: begin
            dec.rd      = instr[5:4];
            dec.rs1     = instr[3:2];
            dec.imm     = {6'b0, instr[1:0]};
            dec.alu_src = 1'b1;
            dec.alu_op  = ADD;
         end
         default: begin
            dec.rs2     = instr[5:4];
            dec.rs1     = instr[3:2];
            dec.imm     = {6'b0, instr[1:0]};
            dec.alu_src = 1'b1;
            dec.alu_op  = ADD;
         end
      endcase
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: FETCH/DECODE/EXEC/MEM/WB sequencer owning pc, IR and
// decoded-field registers. Define MEM_WAIT_TIMEOUT_EN to bound wait states.
module multicycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   multicycle_ctrl_if.master bus
);
   state_e     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] ir_q, ir_d;
   dec_t       dec_q, dec_d, dec_w;
   logic       timeout;
   logic       is_lw, is_sw;

   instr_decode u_dec (.instr(ir_q), .dec(dec_w));

   assign is_lw = (dec_q.opcode == OP_LW);
   assign is_sw = (dec_q.opcode == OP_SW);

`ifdef MEM_WAIT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic             err_q, err_d;
   logic             waiting;

   // Consecutive cycles spent holding a request the memory has not accepted.
   assign waiting = (state_q == FETCH && !bus.imem_ready) ||
                    (state_q == MEM   && !bus.mem_ready);
   assign timeout = waiting && (wcnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wcnt_d = waiting ? wcnt_q + CNT_W'(1) : '0;
      err_d  = err_q | timeout;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wcnt_q <= '0;
         err_q  <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         err_q  <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign timeout = 1'b0;
   assign bus.err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH:   if (bus.imem_ready) state_d = DECODE;
                  else if (timeout)   state_d = HALT;
         DECODE:  state_d = EXEC;
         EXEC:    state_d = (is_lw || is_sw) ? MEM : WB;
         MEM:     if (bus.mem_ready) state_d = is_lw ? WB : FETCH;
                  else if (timeout)  state_d = HALT;
         WB:      state_d = FETCH;
         HALT:    state_d = HALT;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      pc_d  = pc_q;
      ir_d  = ir_q;
      dec_d = dec_q;
      if (state_q == FETCH && bus.imem_ready) begin
         ir_d = bus.imem_rdata;
         pc_d = pc_q + 8'd1;
      end
      if (state_q == DECODE) dec_d = dec_w;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q  <= '0;
         ir_q  <= '0;
         dec_q <= '0;
      end else begin
         pc_q  <= pc_d;
         ir_q  <= ir_d;
         dec_q <= dec_d;
      end
   end

   // Strobes are gated by reset so they drop the instant reset rises, not at the next edge.
   always_comb begin
      bus.imem_req = 1'b0;
      bus.mem_req  = 1'b0;
      bus.mem_we   = 1'b0;
      bus.reg_we   = 1'b0;
      bus.wb_sel   = 1'b0;
      bus.retired  = 1'b0;
      if (!reset) begin
         case (state_q)
            FETCH: bus.imem_req = 1'b1;
            MEM: begin
               bus.mem_req = 1'b1;
               bus.mem_we  = is_sw;
               bus.retired = is_sw && bus.mem_ready;
            end
            WB: begin
               bus.reg_we  = 1'b1;
               bus.wb_sel  = is_lw;
               bus.retired = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.pc       = pc_q;
   assign bus.rs1_addr = dec_q.rs1;
   assign bus.rs2_addr = dec_q.rs2;
   assign bus.rd_addr  = dec_q.rd;
   assign bus.imm      = dec_q.imm;
   assign bus.alu_op   = dec_q.alu_op;
   assign bus.alu_src  = dec_q.alu_src;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction timing, decoded fields,
// pc wrap, reset during a wait, and fetch wait-state behaviour.
module tb_multicycle_ctrl;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   int   r_we_cyc, r_ret_cyc, r_ret_n, r_mreq_n, r_ovl;
   logic r_memwe, r_regwe, r_wbs;

   multicycle_ctrl_if bus ();

   multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.imem_ready = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.imem_rdata = 8'h00;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Runs one instruction from its first FETCH cycle; instruction memory answers
   // with zero wait, data memory after mdly not-ready cycles. Ends one cycle after retire.
   task automatic run_instr(input logic [7:0] instr, input int mdly);
      int  mcnt;
      bit  done;
      mcnt = 0; done = 0;
      r_we_cyc = 0; r_ret_cyc = 0; r_ret_n = 0; r_mreq_n = 0; r_ovl = 0;
      r_memwe = 0; r_regwe = 0; r_wbs = 0;
      for (int c = 1; c <= 20 && !done; c++) begin
         bus.imem_rdata = instr;
         bus.imem_ready = 1'b1;
         bus.mem_ready  = bus.mem_req ? (mcnt >= mdly) : 1'b1;
         #1;
         if (bus.mem_req) begin
            r_mreq_n++;
            mcnt++;
            if (bus.mem_we) r_memwe = 1'b1;
         end
         if (bus.reg_we) begin
            r_regwe  = 1'b1;
            r_we_cyc = c;
            r_wbs    = bus.wb_sel;
         end
         if (bus.retired) begin
            r_ret_n++;
            r_ret_cyc = c;
            done = 1;
         end
         if (32'(bus.reg_we) + 32'(bus.mem_req) + 32'(bus.imem_req) > 1) r_ovl++;
         @(posedge clk);
         #1;
      end
      bus.imem_ready = 1'b0;
      bus.mem_ready  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.imem_ready = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.imem_rdata = 8'h00;
      tick();
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_imem_req got %b exp 0", bus.imem_req); end
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b exp 0", bus.mem_req); end
      checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we got %b exp 0", bus.mem_we); end
      checks++; if (bus.reg_we !== 1'b0) begin errors++; $display("FAIL rst_reg_we got %b exp 0", bus.reg_we); end
      checks++; if (bus.retired !== 1'b0) begin errors++; $display("FAIL rst_retired got %b exp 0", bus.retired); end
      checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL rst_pc got %h exp 00", bus.pc); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus.err); end
      checks++; if ({bus.imm, bus.alu_op, bus.alu_src} !== 11'd0) begin errors++; $display("FAIL rst_fields got %h exp 0", {bus.imm, bus.alu_op, bus.alu_src}); end
      reset = 1'b0;
      #1;
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL rst_first_fetch got %b exp 1", bus.imem_req); end
      tick();
   endtask

   task automatic test_rtype();
      do_reset();
      run_instr(8'b00_01_10_01, 0);
      checks++; if (bus.rs1_addr !== 2'd1) begin errors++; $display("FAIL sub_rs1 got %0d exp 1", bus.rs1_addr); end
      checks++; if (bus.rd_addr !== 2'd1) begin errors++; $display("FAIL sub_rd got %0d exp 1", bus.rd_addr); end
      checks++; if (bus.rs2_addr !== 2'd2) begin errors++; $display("FAIL sub_rs2 got %0d exp 2", bus.rs2_addr); end
      checks++; if (bus.alu_op !== 2'b01) begin errors++; $display("FAIL sub_alu_op got %b exp 01", bus.alu_op); end
      checks++; if (bus.alu_src !== 1'b0) begin errors++; $display("FAIL sub_alu_src got %b exp 0", bus.alu_src); end
      checks++; if (r_we_cyc !== 4) begin errors++; $display("FAIL sub_reg_we_cycle got %0d exp 4", r_we_cyc); end
      checks++; if (r_ret_n !== 1 || r_ret_cyc !== 4) begin errors++; $display("FAIL sub_retired got n=%0d cyc=%0d exp n=1 cyc=4", r_ret_n, r_ret_cyc); end
      checks++; if (bus.retired !== 1'b0) begin errors++; $display("FAIL sub_retired_single got %b exp 0", bus.retired); end
      checks++; if (r_mreq_n !== 0 || r_wbs !== 1'b0) begin errors++; $display("FAIL sub_no_mem got mreq=%0d wb_sel=%b exp 0 0", r_mreq_n, r_wbs); end
      checks++; if (bus.pc !== 8'h01) begin errors++; $display("FAIL sub_pc got %h exp 01", bus.pc); end
      checks++; if (r_ovl !== 0) begin errors++; $display("FAIL sub_strobe_overlap got %0d exp 0", r_ovl); end
      run_instr(8'b00_10_11_11, 0);
      checks++; if ({bus.rd_addr, bus.rs1_addr, bus.rs2_addr, bus.alu_op} !== 8'b10_10_11_11) begin errors++; $display("FAIL and_fields got %b exp 10101111", {bus.rd_addr, bus.rs1_addr, bus.rs2_addr, bus.alu_op}); end
   endtask

   task automatic test_addi();
      do_reset();
      run_instr(8'b01_11_1110, 0);
      checks++; if (bus.imm !== 8'hFE) begin errors++; $display("FAIL addi_imm got %h exp fe", bus.imm); end
      checks++; if (bus.alu_src !== 1'b1) begin errors++; $display("FAIL addi_alu_src got %b exp 1", bus.alu_src); end
      checks++; if (bus.rd_addr !== 2'd3 || bus.rs1_addr !== 2'd3) begin errors++; $display("FAIL addi_rd got rd=%0d rs1=%0d exp 3 3", bus.rd_addr, bus.rs1_addr); end
      checks++; if (bus.alu_op !== 2'b00) begin errors++; $display("FAIL addi_alu_op got %b exp 00", bus.alu_op); end
      checks++; if (r_we_cyc !== 4 || r_ret_cyc !== 4) begin errors++; $display("FAIL addi_timing got we=%0d ret=%0d exp 4 4", r_we_cyc, r_ret_cyc); end
      run_instr(8'b01_00_0111, 0);
      checks++; if (bus.imm !== 8'h07) begin errors++; $display("FAIL addi_pos_imm got %h exp 07", bus.imm); end
   endtask

   task automatic test_lw();
      do_reset();
      run_instr(8'b10_00_01_11, 3);
      checks++; if (bus.rd_addr !== 2'd0 || bus.rs1_addr !== 2'd1) begin errors++; $display("FAIL lw_regs got rd=%0d rs1=%0d exp 0 1", bus.rd_addr, bus.rs1_addr); end
      checks++; if (bus.imm !== 8'h03 || bus.alu_src !== 1'b1) begin errors++; $display("FAIL lw_imm got imm=%h src=%b exp 03 1", bus.imm, bus.alu_src); end
      checks++; if (r_mreq_n !== 4) begin errors++; $display("FAIL lw_mem_req_cycles got %0d exp 4", r_mreq_n); end
      checks++; if (r_memwe !== 1'b0) begin errors++; $display("FAIL lw_mem_we got %b exp 0", r_memwe); end
      checks++; if (r_wbs !== 1'b1) begin errors++; $display("FAIL lw_wb_sel got %b exp 1", r_wbs); end
      checks++; if (r_ret_cyc !== 8 || r_we_cyc !== 8) begin errors++; $display("FAIL lw_retire_cycle got ret=%0d we=%0d exp 8 8", r_ret_cyc, r_we_cyc); end
      checks++; if (r_ovl !== 0) begin errors++; $display("FAIL lw_strobe_overlap got %0d exp 0", r_ovl); end
      run_instr(8'b10_01_00_00, 0);
      checks++; if (r_ret_cyc !== 5) begin errors++; $display("FAIL lw_zero_wait got %0d exp 5", r_ret_cyc); end
   endtask

   task automatic test_sw_wrap();
      do_reset();
      for (int i = 0; i < 300 && bus.pc !== 8'hFF; i++) run_instr(8'h00, 0);
      checks++; if (bus.pc !== 8'hFF) begin errors++; $display("FAIL sw_reach_ff got %h exp ff", bus.pc); end
      run_instr(8'b11_10_01_10, 0);
      checks++; if (bus.pc !== 8'h00) begin errors++; $display("FAIL sw_pc_wrap got %h exp 00", bus.pc); end
      checks++; if (r_memwe !== 1'b1) begin errors++; $display("FAIL sw_mem_we got %b exp 1", r_memwe); end
      checks++; if (r_regwe !== 1'b0) begin errors++; $display("FAIL sw_reg_we got %b exp 0", r_regwe); end
      checks++; if (r_ret_n !== 1 || r_ret_cyc !== 4) begin errors++; $display("FAIL sw_retire got n=%0d cyc=%0d exp 1 4", r_ret_n, r_ret_cyc); end
      checks++; if ({bus.rs2_addr, bus.rs1_addr, bus.imm} !== 12'b10_01_00000010) begin errors++; $display("FAIL sw_fields got %b exp 100100000010", {bus.rs2_addr, bus.rs1_addr, bus.imm}); end
   endtask

   task automatic test_reset_mid_mem();
      do_reset();
      bus.imem_rdata = 8'b10_11_01_11;
      bus.imem_ready = 1'b1;
      bus.mem_ready  = 1'b0;
      tick(); tick(); tick(); tick();
      checks++; if (bus.mem_req !== 1'b1 || bus.rd_addr !== 2'd3) begin errors++; $display("FAIL mid_mem_wait got req=%b rd=%0d exp 1 3", bus.mem_req, bus.rd_addr); end
      #1;
      reset = 1'b1;
      #1;
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mid_mem_req_drop got %b exp 0", bus.mem_req); end
      checks++; if (bus.pc !== 8'h00 || bus.rd_addr !== 2'd0 || bus.imm !== 8'h00) begin errors++; $display("FAIL mid_mem_clear got pc=%h rd=%0d imm=%h exp 00 0 00", bus.pc, bus.rd_addr, bus.imm); end
      checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL mid_mem_imem_req got %b exp 0", bus.imem_req); end
      bus.imem_ready = 1'b0;
      tick();
      reset = 1'b0;
      #1;
      checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL mid_mem_refetch got %b exp 1", bus.imem_req); end
      @(posedge clk); #1;
      run_instr(8'b01_01_0001, 0);
      checks++; if (r_ret_cyc !== 4 || bus.pc !== 8'h01) begin errors++; $display("FAIL mid_mem_restart got ret=%0d pc=%h exp 4 01", r_ret_cyc, bus.pc); end
   endtask

   task automatic test_wait_limit();
      int lows;
      do_reset();
`ifdef MEM_WAIT_TIMEOUT_EN
      for (int i = 0; i < 15; i++) tick();
      checks++; if (bus.imem_req !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL to_before got req=%b err=%b exp 1 0", bus.imem_req, bus.err); end
      tick();
      checks++; if (bus.imem_req !== 1'b0 || bus.err !== 1'b1) begin errors++; $display("FAIL to_expire got req=%b err=%b exp 0 1", bus.imem_req, bus.err); end
      bus.imem_ready = 1'b1;
      lows = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.imem_req !== 1'b0 || bus.retired !== 1'b0 || bus.err !== 1'b1) lows++;
      end
      checks++; if (lows !== 0 || bus.pc !== 8'h00) begin errors++; $display("FAIL to_halt got bad=%0d pc=%h exp 0 00", lows, bus.pc); end
`else
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.imem_req !== 1'b1) lows++;
      end
      checks++; if (lows !== 0) begin errors++; $display("FAIL wait_req_held got %0d low cycles exp 0", lows); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL wait_err got %b exp 0", bus.err); end
      bus.imem_rdata = 8'b01_10_0011;
      bus.imem_ready = 1'b1;
      tick();
      bus.imem_ready = 1'b0;
      checks++; if (bus.pc !== 8'h01 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL wait_late_ready got pc=%h req=%b exp 01 0", bus.pc, bus.imem_req); end
`endif
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.imem_ready = 1'b0;
      bus.mem_ready  = 1'b0;
      bus.imem_rdata = 8'h00;
      test_reset();
      test_rtype();
      test_addi();
      test_lw();
      test_sw_wrap();
      test_reset_mid_mem();
      test_wait_limit();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
